// File: rtl/cpu6_dmem_pkg.sv
// Shared cpu6 data-side definitions: MMIO register offsets, console TX state
// encoding and the timer compare reset value.
package cpu6_dmem_pkg;

    localparam logic [7:0] CPU6_MMIO_MTIME_LO    = 8'h00;
    localparam logic [7:0] CPU6_MMIO_MTIME_HI    = 8'h04;
    localparam logic [7:0] CPU6_MMIO_MTIMECMP_LO = 8'h08;
    localparam logic [7:0] CPU6_MMIO_MTIMECMP_HI = 8'h0C;
    localparam logic [7:0] CPU6_MMIO_TXDATA      = 8'h10;
    localparam logic [7:0] CPU6_MMIO_TXSTATUS    = 8'h14;

    localparam logic [63:0] CPU6_MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_PEND = 1'b1
    } tx_state_t;

    // Word-granular register match; the two byte-select bits of the offset are ignored.
    function automatic logic reg_match(input logic [5:0] word_off, input logic [7:0] reg_off);
        return {word_off, 2'b00} == reg_off;
    endfunction

endpackage

// File: rtl/cpu6_dmem_if.sv
// MEM-stage data port between the cpu6 datapath (master) and the data responder (slave).
interface cpu6_dmem_if;
    logic [31:0] dataaddrM;
    logic [31:0] writedataM;
    logic        memwriteM;
    logic [31:0] readdataM;

    modport master (output dataaddrM, output writedataM, output memwriteM, input readdataM);
    modport slave  (input dataaddrM, input writedataM, input memwriteM, output readdataM);
endinterface

// File: rtl/cpu6_mmio_timer.sv
// Free-running 64-bit machine timer with compare register and registered level interrupt.
module cpu6_mmio_timer
    import cpu6_dmem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [5:0]  word_off,
    input  logic [31:0] wdata,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        timer_irq
);

    logic wr_mtime_lo;
    logic wr_mtime_hi;
    logic wr_cmp_lo;
    logic wr_cmp_hi;

    assign wr_mtime_lo = wr_en && reg_match(word_off, CPU6_MMIO_MTIME_LO);
    assign wr_mtime_hi = wr_en && reg_match(word_off, CPU6_MMIO_MTIME_HI);
    assign wr_cmp_lo   = wr_en && reg_match(word_off, CPU6_MMIO_MTIMECMP_LO);
    assign wr_cmp_hi   = wr_en && reg_match(word_off, CPU6_MMIO_MTIMECMP_HI);

    // A store to either mtime half replaces the increment for that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime     <= '0;
            mtimecmp  <= CPU6_MTIMECMP_RESET;
            timer_irq <= 1'b0;
        end else begin
            if (wr_mtime_lo) begin
                mtime[31:0] <= wdata;
            end else if (wr_mtime_hi) begin
                mtime[63:32] <= wdata;
            end else begin
                mtime <= mtime + 64'd1;
            end
            if (wr_cmp_lo) begin
                mtimecmp[31:0] <= wdata;
            end
            if (wr_cmp_hi) begin
                mtimecmp[63:32] <= wdata;
            end
            timer_irq <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/cpu6_dmem.sv
// cpu6 data-side responder: word RAM plus an MMIO window holding the machine
// timer and a one-byte console transmit register.
module cpu6_dmem
    import cpu6_dmem_pkg::*;
#(
    parameter int          DMEM_AW   = 10,
    parameter logic [31:0] MMIO_BASE = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        reset,
    cpu6_dmem_if.slave  bus,
    output logic        timer_irq,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    logic [31:0]        mem [0:(1 << DMEM_AW) - 1];
    logic [DMEM_AW-1:0] ram_idx;
    logic               ram_hit;
    logic               mmio_hit;
    logic [5:0]         word_off;
    logic               mmio_we;
    logic               tx_store;
    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    tx_state_t          tx_state;
    logic               unused_addr_bits;

    assign ram_idx          = bus.dataaddrM[DMEM_AW+1:2];
    assign ram_hit          = (bus.dataaddrM[31:DMEM_AW+2] == '0);
    assign mmio_hit         = (bus.dataaddrM[31:8] == MMIO_BASE[31:8]);
    assign word_off         = bus.dataaddrM[7:2];
    assign mmio_we          = bus.memwriteM && mmio_hit;
    assign tx_store         = mmio_we && reg_match(word_off, CPU6_MMIO_TXDATA);
    assign unused_addr_bits = ^bus.dataaddrM[1:0];

    cpu6_mmio_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (mmio_we),
        .word_off  (word_off),
        .wdata     (bus.writedataM),
        .mtime     (mtime),
        .mtimecmp  (mtimecmp),
        .timer_irq (timer_irq)
    );

    // RAM contents survive reset; only the store itself is suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && bus.memwriteM && ram_hit) begin
            mem[ram_idx] <= bus.writedataM;
        end
    end

    always_comb begin
        bus.readdataM = '0;
        if (ram_hit) begin
            bus.readdataM = mem[ram_idx];
        end else if (mmio_hit) begin
            case ({word_off, 2'b00})
                CPU6_MMIO_MTIME_LO:    bus.readdataM = mtime[31:0];
                CPU6_MMIO_MTIME_HI:    bus.readdataM = mtime[63:32];
                CPU6_MMIO_MTIMECMP_LO: bus.readdataM = mtimecmp[31:0];
                CPU6_MMIO_MTIMECMP_HI: bus.readdataM = mtimecmp[63:32];
                CPU6_MMIO_TXSTATUS:    bus.readdataM = {31'b0, tx_valid};
                default:               bus.readdataM = '0;
            endcase
        end
    end

    // A TXDATA store while a byte is pending is dropped, even on the handshake cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_store) begin
                        tx_state <= TX_PEND;
                        tx_valid <= 1'b1;
                        tx_data  <= bus.writedataM[7:0];
                    end
                end
                TX_PEND: begin
                    if (tx_ready) begin
                        tx_state <= TX_IDLE;
                        tx_valid <= 1'b0;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu6_dmem.sv
// Directed bench for cpu6_dmem: RAM, decode, timer, interrupt, console TX and reset,
// checked through an expected-value scoreboard.
module tb_cpu6_dmem;

    localparam logic [31:0] MB      = 32'hF000_0000;
    localparam logic [31:0] A_MLO   = MB + 32'h00;
    localparam logic [31:0] A_MHI   = MB + 32'h04;
    localparam logic [31:0] A_CLO   = MB + 32'h08;
    localparam logic [31:0] A_CHI   = MB + 32'h0C;
    localparam logic [31:0] A_TXD   = MB + 32'h10;
    localparam logic [31:0] A_TXS   = MB + 32'h14;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       timer_irq;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];

    cpu6_dmem_if bus ();

    cpu6_dmem dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .timer_irq (timer_irq),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic we);
        bus.dataaddrM  = addr;
        bus.writedataM = data;
        bus.memwriteM  = we;
    endtask

    task automatic expectVal(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty observed %h expected none", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.val) else begin
                errors++;
                $error("[TB] FAIL %s observed %h expected %h", e.tag, observed, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic storeCycle(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(addr, data, 1'b1);
        tick(1);
        applyStimulus(addr, 32'h0, 1'b0);
    endtask

    task automatic readAt(input logic [31:0] addr, input logic [31:0] val, input string tag);
        applyStimulus(addr, 32'h0, 1'b0);
        expectVal(tag, val);
        #1;
        checkOutput(bus.readdataM);
    endtask

    task automatic checkSig(input string tag, input logic [31:0] observed, input logic [31:0] val);
        expectVal(tag, val);
        checkOutput(observed);
    endtask

    initial begin
        reset    = 1'b1;
        tx_ready = 1'b0;
        applyStimulus(32'h0, 32'h0, 1'b0);
        tick(3);

        checkSig("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        checkSig("rst_tx_data", {24'b0, tx_data}, 32'h0);
        checkSig("rst_irq", {31'b0, timer_irq}, 32'h0);
        readAt(A_MLO, 32'h0, "rst_mtime_lo");
        readAt(A_CHI, 32'hFFFF_FFFF, "rst_mtimecmp_hi");
        reset = 1'b0;

        tick(100);
        readAt(A_MLO, 32'd100, "mtime_after_100");
        readAt(A_MHI, 32'd0, "mtime_hi_after_100");
        storeCycle(A_MHI, 32'd1);
        readAt(A_MLO, 32'd100, "mtime_lo_held");
        readAt(A_MHI, 32'd1, "mtime_hi_written");
        storeCycle(A_MHI, 32'd0);
        storeCycle(A_MLO, 32'hFFFF_FFFF);
        readAt(A_MLO, 32'hFFFF_FFFF, "mtime_lo_max");
        readAt(A_MHI, 32'd0, "mtime_hi_before_carry");
        tick(1);
        readAt(A_MLO, 32'd0, "mtime_lo_carry");
        readAt(A_MHI, 32'd1, "mtime_hi_carry");

        storeCycle(A_MHI, 32'd0);
        storeCycle(A_CHI, 32'd0);
        storeCycle(A_CLO, 32'd11);
        checkSig("irq_low_start", {31'b0, timer_irq}, 32'h0);
        readAt(A_MLO, 32'd2, "mtime_irq_base");
        tick(9);
        readAt(A_MLO, 32'd11, "mtime_at_cmp");
        checkSig("irq_low_at_cmp", {31'b0, timer_irq}, 32'h0);
        tick(1);
        checkSig("irq_rise", {31'b0, timer_irq}, 32'h1);
        storeCycle(A_CHI, 32'hFFFF_FFFF);
        checkSig("irq_lag_after_cmp_write", {31'b0, timer_irq}, 32'h1);
        tick(1);
        checkSig("irq_fall", {31'b0, timer_irq}, 32'h0);
        storeCycle(A_CHI, 32'd0);
        checkSig("irq_lag_before_raise", {31'b0, timer_irq}, 32'h0);
        tick(1);
        checkSig("irq_raise_by_cmp_write", {31'b0, timer_irq}, 32'h1);

        storeCycle(32'h0000_0014, 32'h0);
        storeCycle(32'h0000_0000, 32'hCAFE_0000);
        storeCycle(32'h0000_0010, 32'hDEAD_BEEF);
        readAt(32'h0000_0010, 32'hDEAD_BEEF, "ram_load");
        readAt(32'h0000_0013, 32'hDEAD_BEEF, "ram_load_unaligned");
        readAt(32'h0000_0014, 32'h0, "ram_next_word");
        storeCycle(32'h0000_0FFC, 32'hA5A5_A5A5);
        readAt(32'h0000_0FFC, 32'hA5A5_A5A5, "ram_last_word");
        storeCycle(32'h4000_0000, 32'h1234);
        readAt(32'h4000_0000, 32'h0, "unmapped_load");
        storeCycle(32'h0000_1000, 32'h5555);
        readAt(32'h0000_1000, 32'h0, "unmapped_above_ram");
        readAt(32'h0000_0000, 32'hCAFE_0000, "ram_word0_intact");
        readAt(MB + 32'h18, 32'h0, "mmio_unlisted");
        readAt(MB + 32'h100, 32'h0, "outside_mmio_window");

        storeCycle(A_TXD, 32'h0000_0041);
        checkSig("tx_valid_set", {31'b0, tx_valid}, 32'h1);
        checkSig("tx_data_41", {24'b0, tx_data}, 32'h41);
        readAt(A_TXS, 32'h1, "txstatus_pending");
        readAt(A_TXD, 32'h0, "txdata_reads_zero");
        storeCycle(A_TXD, 32'h0000_0042);
        checkSig("tx_drop_while_pend", {24'b0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        checkSig("tx_valid_clear", {31'b0, tx_valid}, 32'h0);
        checkSig("tx_data_kept", {24'b0, tx_data}, 32'h41);
        readAt(A_TXS, 32'h0, "txstatus_idle");
        storeCycle(A_TXD, 32'h0000_0043);
        checkSig("tx_data_43", {24'b0, tx_data}, 32'h43);
        tx_ready = 1'b1;
        storeCycle(A_TXD, 32'h0000_0044);
        tx_ready = 1'b0;
        checkSig("tx_handshake_store_valid", {31'b0, tx_valid}, 32'h0);
        checkSig("tx_handshake_store_data", {24'b0, tx_data}, 32'h43);
        tick(1);
        checkSig("tx_handshake_store_gone", {31'b0, tx_valid}, 32'h0);

        storeCycle(A_TXD, 32'h0000_0055);
        checkSig("pre_reset_tx_valid", {31'b0, tx_valid}, 32'h1);
        checkSig("pre_reset_irq", {31'b0, timer_irq}, 32'h1);
        reset = 1'b1;
        applyStimulus(A_MLO, 32'h77, 1'b1);
        tick(1);
        reset = 1'b0;
        applyStimulus(32'h0, 32'h0, 1'b0);
        checkSig("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
        checkSig("reset_tx_data", {24'b0, tx_data}, 32'h0);
        checkSig("reset_irq", {31'b0, timer_irq}, 32'h0);
        readAt(A_MLO, 32'h0, "reset_mtime_lo");
        readAt(A_MHI, 32'h0, "reset_mtime_hi");
        readAt(A_CLO, 32'hFFFF_FFFF, "reset_mtimecmp_lo");
        readAt(32'h0000_0010, 32'hDEAD_BEEF, "ram_survives_reset");
        tick(1);
        readAt(A_MLO, 32'h1, "mtime_counts_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
